vedic_mult_seq: RTL and testbench



---
 rtl/vedic_pkg.sv | 22 ++
 rtl/vedic_4_x_4.sv | 34 +++
 rtl/vedic_mult_seq.sv | 152 +++++++++++++++
 tb/tb_vedic_mult_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiplier.
// Holds the FSM state type, the tile digit width and a digit slicer.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int TILE_W = 4;
  localparam int MAX_W  = 256;

  // Operands are zero-extended to MAX_W so one function serves every WIDTH.
  function automatic logic [TILE_W-1:0] digit(
    input logic [MAX_W-1:0] vec,
    input int               idx
  );
    return vec[idx*TILE_W +: TILE_W];
  endfunction

endpackage

// File: rtl/vedic_4_x_4.sv
// 4x4 Urdhva-Tiryagbhyam tile: four 2x2 vertical/crosswise products.
// Ports: a_i, b_i (4-bit digits) -> p_o (8-bit product).
module vedic_4_x_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  function automatic logic [3:0] v2x2(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [1:0] t;
    logic [1:0] u;
    t = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    u = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
    return {u, t[0], x[0] & y[0]};
  endfunction

  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;

  always_comb begin
    q0  = v2x2(a_i[1:0], b_i[1:0]);
    q1  = v2x2(a_i[3:2], b_i[1:0]);
    q2  = v2x2(a_i[1:0], b_i[3:2]);
    q3  = v2x2(a_i[3:2], b_i[3:2]);
    mid = {1'b0, q1} + {1'b0, q2};
    p_o = 8'(q0)
        + (8'(mid) << 2)
        + (8'(q3) << 4);
  end

endmodule

// File: rtl/vedic_mult_seq.sv
// Sequential Vedic multiplier: one 4x4 tile per cycle into a 2*WIDTH acc.
// Ports: clk, rst_n, in_valid/in_ready/a/b in, out_valid/out_ready/product out,
// busy. Macro VEDIC_MULT_SIGNED_EN adds is_signed (two's complement operands).
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int DIGITS = WIDTH / TILE_W;
  localparam int TILES  = DIGITS * DIGITS;
  localparam int PW     = 2 * WIDTH;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  generate
    if ((WIDTH % TILE_W) != 0 || WIDTH < TILE_W || WIDTH > MAX_W)
      $error("vedic_mult_seq: bad WIDTH %0d", WIDTH);
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  a_in, b_in;
  logic [TILE_W-1:0] da, db;
  logic [7:0]        tile_p;
  logic [PW-1:0]     acc_sum, acc_fin;
  logic              last;

  vedic_4_x_4 u_tile (
    .a_i (da),
    .b_i (db),
    .p_o (tile_p)
  );

`ifdef VEDIC_MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic sa, sb;

  // Magnitudes are WIDTH-bit unsigned, so the most negative value fits.
  always_comb begin
    sa    = is_signed & a[WIDTH-1];
    sb    = is_signed & b[WIDTH-1];
    a_in  = sa ? -a : a;
    b_in  = sb ? -b : b;
    neg_d = neg_q;
    if (state_q == IDLE && in_valid)
      neg_d = sa ^ sb;
    acc_fin = neg_q ? -acc_sum : acc_sum;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
`else
  always_comb begin
    a_in    = a;
    b_in    = b;
    acc_fin = acc_sum;
  end
`endif

  always_comb begin
    da      = digit(MAX_W'(a_q), int'(i_q));
    db      = digit(MAX_W'(b_q), int'(j_q));
    acc_sum = acc_q
            + (PW'(tile_p) << (TILE_W * (int'(i_q) + int'(j_q))));
    last    = (i_q == LAST) && (j_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        if (last) begin
          prod_d  = acc_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq at WIDTH 8, 16 and 4.
// Edge numbering: the accepting edge is edge 1.
module tb_vedic_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iv8, ir8, ov8, or8, bz8, sg8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv16, ir16, ov16, or16, bz16, sg16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        iv4, ir4, ov4, or4, bz4, sg4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  vedic_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8),
`ifdef VEDIC_MULT_SIGNED_EN
    .is_signed(sg8),
`endif
    .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(bz8)
  );

  vedic_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16),
`ifdef VEDIC_MULT_SIGNED_EN
    .is_signed(sg16),
`endif
    .out_valid(ov16), .out_ready(or16),
    .product(p16), .busy(bz16)
  );

  vedic_mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4),
`ifdef VEDIC_MULT_SIGNED_EN
    .is_signed(sg4),
`endif
    .out_valid(ov4), .out_ready(or4),
    .product(p4), .busy(bz4)
  );

  // Drives one WIDTH=8 transaction; returns product and the edge on
  // which out_valid was first seen. Comparisons live in the callers.
  task automatic op8(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic        s,
    output logic [15:0] p,
    output int          lat,
    output logic        ir_seen,
    output logic        bz_low
  );
    iv8 = 1'b1; a8 = x; b8 = y; sg8 = s;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hC3; b8 = 8'h3C; sg8 = ~s;
    lat = 1; ir_seen = ir8; bz_low = !bz8;
    while (!ov8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      ir_seen |= ir8;
      bz_low  |= !bz8;
    end
    p = p8;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", ir8);
    end
    checks++;
    if (ov8 !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", ov8);
    end
    checks++;
    if (bz8 !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", bz8);
    end
    checks++;
    if (p8 !== 16'h0000 || p16 !== 32'h0) begin
      errors++; $display("FAIL rst_product got %h/%h want 0", p8, p16);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max();
    logic [15:0] p; int lat; logic irs, bzl;
    or8 = 1'b1;
    op8(8'hFF, 8'hFF, 1'b0, p, lat, irs, bzl);
    checks++;
    if (p !== 16'hFE01) begin
      errors++; $display("FAIL max_prod got %h want fe01", p);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL max_latency got %0d want 5", lat);
    end
    checks++;
    if (irs !== 1'b0) begin
      errors++; $display("FAIL max_in_ready_busy got 1 want 0");
    end
    checks++;
    if (bzl !== 1'b0) begin
      errors++; $display("FAIL max_busy got low want high");
    end
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL max_drain ov %b ir %b want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] p; int lat; logic irs, bzl;
    op8(8'h00, 8'hA7, 1'b0, p, lat, irs, bzl);
    checks++;
    if (p !== 16'h0000) begin
      errors++; $display("FAIL zero_prod got %h want 0000", p);
    end
    @(posedge clk); #1;
    op8(8'h0D, 8'h0B, 1'b0, p, lat, irs, bzl);
    checks++;
    if (p !== 16'h008F) begin
      errors++; $display("FAIL small_prod got %h want 008f", p);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL small_latency got %0d want 5", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] p; int lat; logic irs, bzl;
    or8 = 1'b0;
    op8(8'h12, 8'h34, 1'b0, p, lat, irs, bzl);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b1 || p8 !== 16'h03A8 || ir8 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d ov %b p %h ir %b want 1 03a8 0",
                 k, ov8, p8, ir8);
      end
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ir %b ov %b want 1 0", ir8, ov8);
    end
    checks++;
    if (p8 !== 16'h03A8) begin
      errors++; $display("FAIL bp_keep got %h want 03a8", p8);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; int lat; logic irs, bzl; logic saw;
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'h33; sg8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || p8 !== 16'h0 || ir8 !== 1'b1 || bz8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst ov %b p %h ir %b bz %b want 0 0000 1 0",
               ov8, p8, ir8, bz8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      saw |= ov8;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++; $display("FAIL mid_no_result got out_valid want none");
    end
    op8(8'h10, 8'h10, 1'b0, p, lat, irs, bzl);
    checks++;
    if (p !== 16'h0100) begin
      errors++; $display("FAIL mid_next got %h want 0100", p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w16();
    int lat;
    iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0002;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
    lat = 1;
    while (!ov16 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (p16 !== 32'h0001FFFE) begin
      errors++; $display("FAIL w16_prod got %h want 0001fffe", p16);
    end
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL w16_latency got %0d want 17", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w4();
    int lat;
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'h3; b4 = 4'h5;
    lat = 1;
    while (!ov4 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (p4 !== 8'hE1) begin
      errors++; $display("FAIL w4_prod got %h want e1", p4);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL w4_latency got %0d want 2", lat);
    end
    @(posedge clk); #1;
  endtask

`ifdef VEDIC_MULT_SIGNED_EN
  task automatic test_signed();
    logic [15:0] p; int lat; logic irs, bzl;
    op8(8'hFD, 8'h05, 1'b1, p, lat, irs, bzl);
    checks++;
    if (p !== 16'hFFF1) begin
      errors++; $display("FAIL sgn_m3x5 got %h want fff1", p);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL sgn_latency got %0d want 5", lat);
    end
    @(posedge clk); #1;
    op8(8'h80, 8'h80, 1'b1, p, lat, irs, bzl);
    checks++;
    if (p !== 16'h4000) begin
      errors++; $display("FAIL sgn_min_sq got %h want 4000", p);
    end
    @(posedge clk); #1;
    op8(8'h7F, 8'h81, 1'b1, p, lat, irs, bzl);
    checks++;
    if (p !== 16'hC0FF) begin
      errors++; $display("FAIL sgn_127xm127 got %h want c0ff", p);
    end
    @(posedge clk); #1;
    op8(8'h80, 8'h80, 1'b0, p, lat, irs, bzl);
    checks++;
    if (p !== 16'h4000) begin
      errors++; $display("FAIL uns_80x80 got %h want 4000", p);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1; sg8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1; sg16 = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1; sg4 = 1'b0;
    test_reset();
    test_max();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_w16();
    test_w4();
`ifdef VEDIC_MULT_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
